// File: rtl/alu_pipe_if.sv
// Operand/opcode request channel and result/flag response channel of alu_pipe.
// Both channels use valid/ready: a beat moves on a rising edge where valid && ready.
interface alu_pipe_if #(
  parameter int DATA_W = 8,
  parameter int TAG_W  = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_a;
  logic [DATA_W-1:0]     in_b;
  logic [3:0]            in_op;
  logic [TAG_W-1:0]      in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*DATA_W-1:0]   out_result;
  logic [TAG_W-1:0]      out_tag;
  logic                  out_carry;
  logic                  out_zero;
  logic                  out_ovf;
  logic                  out_err;

  modport master (
    output in_valid, in_a, in_b, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_carry, out_zero, out_ovf, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_carry, out_zero, out_ovf, out_err
  );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU: single-cycle ops load the output register on the accept edge,
// MUL runs DATA_W shift-add steps before loading it. Output holds under backpressure.
module alu_pipe #(
  parameter int DATA_W = 8,
  parameter int TAG_W  = 4
) (
  input  logic       clk,
  input  logic       rst,
  alu_pipe_if.slave  bus,
  output logic       busy,
  output logic       dbg_state_o
);
  localparam int RW = 2 * DATA_W;
  localparam int CW = $clog2(DATA_W + 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_INC = 4'd8;
  localparam logic [3:0] OP_DEC = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;
  localparam logic [3:0] OP_CMP = 4'd11;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [RW-1:0]       acc_q, acc_d;
  logic [RW-1:0]       mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [TAG_W-1:0]    mtag_q, mtag_d;
  logic                busy_q, busy_d;

  logic                out_valid_q, out_valid_d;
  logic [RW-1:0]       result_q, result_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic                carry_q, carry_d;
  logic                zero_q, zero_d;
  logic                ovf_q, ovf_d;
  logic                err_q, err_d;

  logic                in_ready;
  logic                accept;
  logic [RW-1:0]       acc_step;

  logic [DATA_W-1:0]   opb;
  logic [DATA_W:0]     add_w, sub_w;
  logic                add_v, sub_v;
  logic [RW-1:0]       alu_res;
  logic                alu_c, alu_z, alu_v, alu_e;

  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // INC/DEC reuse the ADD/SUB datapath with a constant second operand.
  always_comb begin
    opb     = ((bus.in_op == OP_INC) || (bus.in_op == OP_DEC)) ? DATA_W'(1) : bus.in_b;
    add_w   = {1'b0, bus.in_a} + {1'b0, opb};
    sub_w   = {1'b0, bus.in_a} - {1'b0, opb};
    add_v   = (bus.in_a[DATA_W-1] == opb[DATA_W-1]) && (add_w[DATA_W-1] != bus.in_a[DATA_W-1]);
    sub_v   = (bus.in_a[DATA_W-1] != opb[DATA_W-1]) && (sub_w[DATA_W-1] != bus.in_a[DATA_W-1]);
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_e   = 1'b0;
    case (bus.in_op)
      OP_ADD, OP_INC: begin
        alu_res = {{DATA_W{1'b0}}, add_w[DATA_W-1:0]};
        alu_c   = add_w[DATA_W];
        alu_v   = add_v;
      end
      OP_SUB, OP_DEC: begin
        alu_res = {{DATA_W{1'b0}}, sub_w[DATA_W-1:0]};
        alu_c   = sub_w[DATA_W];
        alu_v   = sub_v;
      end
      OP_AND: alu_res = {{DATA_W{1'b0}}, bus.in_a & bus.in_b};
      OP_OR:  alu_res = {{DATA_W{1'b0}}, bus.in_a | bus.in_b};
      OP_XOR: alu_res = {{DATA_W{1'b0}}, bus.in_a ^ bus.in_b};
      OP_NOT: alu_res = {{DATA_W{1'b0}}, ~bus.in_a};
      OP_SHL: begin
        alu_res = {{DATA_W{1'b0}}, bus.in_a[DATA_W-2:0], 1'b0};
        alu_c   = bus.in_a[DATA_W-1];
      end
      OP_SHR: begin
        alu_res = {{DATA_W{1'b0}}, 1'b0, bus.in_a[DATA_W-1:1]};
        alu_c   = bus.in_a[0];
      end
      OP_MUL: alu_res = '0;
      OP_CMP: begin
        alu_c = sub_w[DATA_W];
        alu_v = sub_v;
      end
      default: alu_e = 1'b1;
    endcase
    // An illegal opcode reports only err; zero follows the compare for CMP.
    if (bus.in_op == OP_CMP) alu_z = (bus.in_a == bus.in_b);
    else                     alu_z = !alu_e && (alu_res == '0);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    mtag_d      = mtag_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    result_d    = result_q;
    tag_d       = tag_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.in_op == OP_MUL) begin
            state_d  = S_MUL;
            acc_d    = '0;
            mcand_d  = {{DATA_W{1'b0}}, bus.in_a};
            mplier_d = bus.in_b;
            mtag_d   = bus.in_tag;
            cnt_d    = CW'(DATA_W);
            busy_d   = 1'b1;
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            tag_d       = bus.in_tag;
            carry_d     = alu_c;
            zero_d      = alu_z;
            ovf_d       = alu_v;
            err_d       = alu_e;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        // The output slot is free here: acceptance required it empty or draining.
        if (cnt_q == CW'(1)) begin
          state_d     = S_IDLE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
          result_d    = acc_step;
          tag_d       = mtag_q;
          carry_d     = 1'b0;
          zero_d      = (acc_step == '0);
          ovf_d       = |acc_step[RW-1:DATA_W];
          err_d       = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      mtag_q      <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      tag_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      mtag_q      <= mtag_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      tag_q       <= tag_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = result_q;
  assign bus.out_tag    = tag_q;
  assign bus.out_carry  = carry_q;
  assign bus.out_zero   = zero_q;
  assign bus.out_ovf    = ovf_q;
  assign bus.out_err    = err_q;
  assign busy           = busy_q;
  assign dbg_state_o    = (state_q == S_MUL);
endmodule
